inst_prefetch_buffer: RTL and testbench
=======================================

// Module: inst_prefetch_buffer
// PURPOSE
// - Memory-side responder for inst_cache: serves its line reads and accepts its next-line prefetch requests.
// - Holds one prefetched 256-bit line, so a later demand miss to that line returns in 1 cycle with no memory access.
// - Sits between inst_cache and the memory arbiter. Issues at most one outstanding read to memory.
// PARAMETERS
// - s_offset  5    byte-offset bits per line; line address = addr & ~(2**s_offset-1)
// - s_line    256  line width in bits (8*2**s_offset)
// PORTS
// - clk               in   1       clock
// - rst               in   1       reset; one clock, synchronous, active-high
// - prefetch          in   1       cache requests prefetch (valid; held until accepted)
// - prefetch_address  in   32      prefetch target (any byte address; aligned internally)
// - prefetch_ready    out  1       prefetch accepted when prefetch && prefetch_ready
// - cache_pmem_address in  32      demand line address from cache
// - cache_pmem_read   in   1       demand read; held until cache_pmem_resp
// - cache_pmem_rdata  out  s_line  line returned to cache
// - cache_pmem_resp   out  1       1-cycle pulse; rdata/fetched_address valid this cycle
// - fetched_address   out  32      line-aligned address of the returned line
// - mem_address       out  32      line-aligned read address to arbiter
// - mem_read          out  1       held until mem_resp
// - mem_rdata         in   s_line  line from arbiter
// - mem_resp          in   1       1-cycle completion from arbiter
// BEHAVIOUR
// - Reset: state IDLE, buf_valid=0, every output 0 (prefetch_ready also 0 in the reset cycle).
// - Reset mid-fetch: mem_read drops next cycle. The arbiter resets on the same edge, so the read is abandoned.
// - FSM states are IDLE, DEMAND, PREFETCH, RESPOND.
// - IDLE, cache_pmem_read, buffer hit (buf_valid && buf_addr==line(cache_pmem_address)):
//   - Load the resp register from the buffer and clear buf_valid -> RESPOND. Latency is 1 cycle.
// - IDLE, cache_pmem_read, buffer miss: latch line address -> DEMAND (mem_read=1).
// - IDLE, no demand read: prefetch_ready=1 combinationally.
//   - On accept, line(prefetch_address)==buf_addr && buf_valid: drop the request, stay IDLE.
//   - On accept, any other address: latch pf_addr -> PREFETCH (mem_read=1).
// - A demand read has priority. prefetch_ready=0 whenever cache_pmem_read=1 or state!=IDLE.
// - DEMAND: on mem_resp, capture mem_rdata into the resp register -> RESPOND. The buffer is not written.
// - PREFETCH: the memory read cannot be aborted. On mem_resp the exit depends on the demand read:
//   - cache_pmem_read=1 and line equals pf_addr (promote): resp register <= mem_rdata, buffer stays invalid -> RESPOND.
//   - cache_pmem_read=1 and line differs: buffer <= {1,pf_addr,mem_rdata}, latch demand address -> DEMAND.
//   - cache_pmem_read=0: buffer <= {1,pf_addr,mem_rdata} -> IDLE.
// - RESPOND: cache_pmem_resp=1 for exactly one cycle, with rdata and fetched_address from the resp registers.
//   - Exit is unconditional -> IDLE. The cache drops cache_pmem_read on the same edge.
// - mem_address is stable while mem_read=1. mem_read is deasserted in the cycle after mem_resp.
// - Never two consecutive mem_read transactions without an intervening deassert cycle.
// - Outside RESPOND: cache_pmem_rdata and fetched_address hold their last values; cache_pmem_resp=0.
// - Simultaneous demand and prefetch in IDLE: demand wins. The prefetch stays pending until ready.
// STRUCTURE
// - Package inst_prefetch_pkg:
//   - state enum pf_state_t {IDLE, DEMAND, PREFETCH, RESPOND}
//   - function line_addr(logic [31:0]) and localparams derived from s_offset.
// - Sub-module inst_prefetch_line_buf holds valid/addr/data.
//   - Ports: load, invalidate, addr and data in.
//   - Combinational hit output against a query address.
// - The FSM and the resp registers stay in the top module.
// TESTING
// - Reset: hold rst 2 cycles with cache_pmem_read=1.
//   - Required: all outputs 0, mem_read=0. The first cycle after release shows mem_read=1.
// - Demand miss: read 0x0000_0044.
//   - Required: mem_address=0x0000_0040.
//   - Arbiter returns D1 after 5 cycles. cache_pmem_resp rises 1 cycle after mem_resp, with rdata=D1 and fetched_address=0x40.
// - Prefetch hit: prefetch 0x0000_0060 and complete it with D2. Then demand 0x0000_006C.
//   - Required: resp 1 cycle later with rdata=D2 and no mem_read.
//   - Repeat the demand: it must now miss (buffer invalidated).
// - Promote: accept prefetch 0x80; while PREFETCH is busy, demand 0x84.
//   - Required: a single mem_read. resp=D3 follows the mem_resp; fetched_address=0x80.
// - Conflict: accept prefetch 0xA0; during that fetch, demand 0x100.
//   - Required: a second mem_read to 0x100 only after the 0xA0 mem_resp and one idle cycle.
//   - A later demand 0xA4 is a 1-cycle hit.
// - Duplicate and priority: prefetch 0xA0 while 0xA0 is buffered, so it is dropped with mem_read=0.
//   - Raise prefetch and demand 0xC0 together: prefetch_ready=0 and the demand is fetched first.

Source files
------------

// File: rtl/inst_prefetch_pkg.sv
// Shared types and line-geometry helpers for the instruction prefetch buffer.
package inst_prefetch_pkg;

    localparam int          S_OFFSET  = 5;
    localparam int          S_LINE    = 8 * (2 ** S_OFFSET);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2,
        RESPOND  = 2'd3
    } pf_state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/inst_prefetch_line_buf.sv
// Single-entry line buffer holding one prefetched line; reports a hit against a query address.
module inst_prefetch_line_buf
    import inst_prefetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              invalidate_i,
    input  logic [31:0]       addr_i,
    input  logic [S_LINE-1:0] data_i,
    input  logic [31:0]       query_i,
    output logic              hit_o,
    output logic [S_LINE-1:0] data_o
);

    logic              valid_q;
    logic [31:0]       addr_q;
    logic [S_LINE-1:0] data_q;

    // Entry storage: load wins over invalidate, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= line_addr(addr_i);
            data_q  <= data_i;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign hit_o  = valid_q && (addr_q == line_addr(query_i));
    assign data_o = data_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Memory-side responder for the instruction cache: serves demand line reads and
// holds one next-line prefetch so a later miss to that line returns in one cycle.
module inst_prefetch_buffer
    import inst_prefetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              prefetch,
    input  logic [31:0]       prefetch_address,
    output logic              prefetch_ready,
    input  logic [31:0]       cache_pmem_address,
    input  logic              cache_pmem_read,
    output logic [S_LINE-1:0] cache_pmem_rdata,
    output logic              cache_pmem_resp,
    output logic [31:0]       fetched_address,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    input  logic [S_LINE-1:0] mem_rdata,
    input  logic              mem_resp
);

    pf_state_t         state_q;
    logic              mem_read_q;
    logic [31:0]       mem_address_q;
    logic              resp_q;
    logic [S_LINE-1:0] rdata_q;
    logic [31:0]       fetched_q;

    logic              buf_hit;
    logic              buf_load;
    logic              buf_inv;
    logic [S_LINE-1:0] buf_data;
    logic [31:0]       query_addr;
    logic [31:0]       demand_line;
    logic              promote;

    // A pending demand read owns the hit query; otherwise it checks for a duplicate prefetch
    assign query_addr  = cache_pmem_read ? cache_pmem_address : prefetch_address;
    assign demand_line = line_addr(cache_pmem_address);
    assign promote     = cache_pmem_read && (demand_line == mem_address_q);

    inst_prefetch_line_buf u_line_buf (
        .clk          (clk),
        .rst          (rst),
        .load_i       (buf_load),
        .invalidate_i (buf_inv),
        .addr_i       (mem_address_q),
        .data_i       (mem_rdata),
        .query_i      (query_addr),
        .hit_o        (buf_hit),
        .data_o       (buf_data)
    );

    // Buffer write/invalidate strobes derived from the current state
    always_comb begin
        buf_load = 1'b0;
        buf_inv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cache_pmem_read && buf_hit) begin
                    buf_inv = 1'b1;
                end else begin
                    buf_inv = 1'b0;
                end
            end
            PREFETCH: begin
                if (mem_resp && !promote) begin
                    buf_load = 1'b1;
                end else begin
                    buf_load = 1'b0;
                end
            end
            default: begin
                buf_load = 1'b0;
                buf_inv  = 1'b0;
            end
        endcase
    end

    assign prefetch_ready = !rst && (state_q == IDLE) && !cache_pmem_read;

    // Control FSM with registered memory-side and cache-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_address_q <= 32'd0;
            resp_q        <= 1'b0;
            rdata_q       <= '0;
            fetched_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (cache_pmem_read) begin
                        if (buf_hit) begin
                            rdata_q   <= buf_data;
                            fetched_q <= demand_line;
                            resp_q    <= 1'b1;
                            state_q   <= RESPOND;
                        end else begin
                            mem_address_q <= demand_line;
                            mem_read_q    <= 1'b1;
                            state_q       <= DEMAND;
                        end
                    end else if (prefetch && !buf_hit) begin
                        mem_address_q <= line_addr(prefetch_address);
                        mem_read_q    <= 1'b1;
                        state_q       <= PREFETCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DEMAND: begin
                    // Entered with mem_read low after a prefetch, giving the idle gap
                    if (!mem_read_q) begin
                        mem_read_q <= 1'b1;
                    end else if (mem_resp) begin
                        mem_read_q <= 1'b0;
                        rdata_q    <= mem_rdata;
                        fetched_q  <= mem_address_q;
                        resp_q     <= 1'b1;
                        state_q    <= RESPOND;
                    end else begin
                        state_q <= DEMAND;
                    end
                end
                PREFETCH: begin
                    if (mem_resp) begin
                        mem_read_q <= 1'b0;
                        if (promote) begin
                            rdata_q   <= mem_rdata;
                            fetched_q <= mem_address_q;
                            resp_q    <= 1'b1;
                            state_q   <= RESPOND;
                        end else if (cache_pmem_read) begin
                            mem_address_q <= demand_line;
                            state_q       <= DEMAND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= PREFETCH;
                    end
                end
                RESPOND: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    resp_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign mem_read         = mem_read_q;
    assign mem_address      = mem_address_q;
    assign cache_pmem_resp  = resp_q;
    assign cache_pmem_rdata = rdata_q;
    assign fetched_address  = fetched_q;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed, table-driven bench for inst_prefetch_buffer plus one hand-sequenced demand miss.
module tb_inst_prefetch_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         prefetch = 1'b0;
    logic [31:0]  prefetch_address = 32'd0;
    logic         prefetch_ready;
    logic [31:0]  cache_pmem_address = 32'd0;
    logic         cache_pmem_read = 1'b0;
    logic [255:0] cache_pmem_rdata;
    logic         cache_pmem_resp;
    logic [31:0]  fetched_address;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] dat [0:7];

    // ctl = {rst, prefetch, cache_pmem_read, mem_resp}; ex = {prefetch_ready, mem_read, resp}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] pfa;
        logic [31:0] rda;
        logic [2:0]  msel;
        logic [2:0]  ex;
        logic [31:0] maddr;
        logic        chk;
        logic [2:0]  esel;
        logic [31:0] faddr;
    } vec_t;

    vec_t vq[$];

    inst_prefetch_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .prefetch           (prefetch),
        .prefetch_address   (prefetch_address),
        .prefetch_ready     (prefetch_ready),
        .cache_pmem_address (cache_pmem_address),
        .cache_pmem_read    (cache_pmem_read),
        .cache_pmem_rdata   (cache_pmem_rdata),
        .cache_pmem_resp    (cache_pmem_resp),
        .fetched_address    (fetched_address),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_rdata          (mem_rdata),
        .mem_resp           (mem_resp)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] pfa, input logic [31:0] rda,
                                input logic [2:0] msel, input logic [2:0] ex, input logic [31:0] maddr,
                                input logic chk, input logic [2:0] esel, input logic [31:0] faddr);
        vec_t v;
        v.ctl = ctl; v.pfa = pfa; v.rda = rda; v.msel = msel; v.ex = ex;
        v.maddr = maddr; v.chk = chk; v.esel = esel; v.faddr = faddr;
        return v;
    endfunction

    task automatic chk1(input int idx, input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %b expected %b", idx, nm, act, exp);
        end
    endtask

    task automatic chk32(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic chk256(input int idx, input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        @(negedge clk);
        rst                = v.ctl[3];
        prefetch           = v.ctl[2];
        prefetch_address   = v.pfa;
        cache_pmem_read    = v.ctl[1];
        cache_pmem_address = v.rda;
        mem_resp           = v.ctl[0];
        mem_rdata          = dat[v.msel];
        #1;
        chk1(idx, "prefetch_ready", prefetch_ready, v.ex[2]);
        @(posedge clk);
        #1;
        chk1(idx, "mem_read", mem_read, v.ex[1]);
        chk1(idx, "cache_pmem_resp", cache_pmem_resp, v.ex[0]);
        if (v.ex[1] || v.ctl[3]) chk32(idx, "mem_address", mem_address, v.maddr);
        if (v.chk) begin
            chk256(idx, "cache_pmem_rdata", cache_pmem_rdata, dat[v.esel]);
            chk32(idx, "fetched_address", fetched_address, v.faddr);
        end
    endtask

    // Demand miss where the bench plays the arbiter with bounded waits
    task automatic seq_demand_wait();
        int n;
        @(negedge clk);
        prefetch           = 1'b0;
        cache_pmem_read    = 1'b1;
        cache_pmem_address = 32'h0000_01F0;
        n = 0;
        while (!mem_read && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1(-1, "seq mem_read raised", mem_read, 1'b1);
        chk32(-1, "seq mem_address", mem_address, 32'h0000_01E0);
        repeat (2) @(negedge clk);
        chk1(-1, "seq no early resp", cache_pmem_resp, 1'b0);
        mem_resp  = 1'b1;
        mem_rdata = dat[3];
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        chk1(-1, "seq resp", cache_pmem_resp, 1'b1);
        chk256(-1, "seq rdata", cache_pmem_rdata, dat[3]);
        chk32(-1, "seq fetched_address", fetched_address, 32'h0000_01E0);
        chk1(-1, "seq mem_read dropped", mem_read, 1'b0);
        @(negedge clk);
        chk1(-1, "seq resp one cycle", cache_pmem_resp, 1'b0);
        cache_pmem_read = 1'b0;
        @(negedge clk);
        chk1(-1, "seq idle mem_read", mem_read, 1'b0);
        chk1(-1, "seq idle ready", prefetch_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dat[0] = '0;
        for (int k = 1; k < 8; k++) dat[k] = {8{32'hDA7A_0000 + 32'(k)}};

        // Reset with demand held, then demand miss to 0x44
        vq.push_back(mk(4'b1010, 32'h0,   32'h44,  3'd0, 3'b000, 32'h0,   1'b1, 3'd0, 32'h0));
        vq.push_back(mk(4'b1010, 32'h0,   32'h44,  3'd0, 3'b000, 32'h0,   1'b1, 3'd0, 32'h0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(4'b0010, 32'h0, 32'h44, 3'd0, 3'b010, 32'h40, 1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'h44,  3'd1, 3'b001, 32'h0,   1'b1, 3'd1, 32'h40));
        vq.push_back(mk(4'b0010, 32'h0,   32'h44,  3'd0, 3'b000, 32'h0,   1'b1, 3'd1, 32'h40));
        // Prefetch 0x60, hit on 0x6C, then repeat misses
        vq.push_back(mk(4'b0100, 32'h60,  32'h0,   3'd0, 3'b110, 32'h60,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0000, 32'h0,   32'h0,   3'd0, 3'b010, 32'h60,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0001, 32'h0,   32'h0,   3'd2, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'h6C,  3'd0, 3'b001, 32'h0,   1'b1, 3'd2, 32'h60));
        vq.push_back(mk(4'b0010, 32'h0,   32'h6C,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'h6C,  3'd0, 3'b010, 32'h60,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'h6C,  3'd4, 3'b001, 32'h0,   1'b1, 3'd4, 32'h60));
        vq.push_back(mk(4'b0010, 32'h0,   32'h6C,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        // Promote: prefetch 0x80, demand 0x84 during the fetch
        vq.push_back(mk(4'b0100, 32'h80,  32'h0,   3'd0, 3'b110, 32'h80,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'h84,  3'd0, 3'b010, 32'h80,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'h84,  3'd3, 3'b001, 32'h0,   1'b1, 3'd3, 32'h80));
        vq.push_back(mk(4'b0010, 32'h0,   32'h84,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0000, 32'h0,   32'h0,   3'd0, 3'b100, 32'h0,   1'b0, 3'd0, 32'h0));
        // Conflict: prefetch 0xA0, demand 0x100 during the fetch
        vq.push_back(mk(4'b0100, 32'hA0,  32'h0,   3'd0, 3'b110, 32'hA0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'h100, 3'd0, 3'b010, 32'hA0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'h100, 3'd5, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'h100, 3'd0, 3'b010, 32'h100, 1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'h100, 3'd6, 3'b001, 32'h0,   1'b1, 3'd6, 32'h100));
        vq.push_back(mk(4'b0010, 32'h0,   32'h100, 3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        // Duplicate prefetch of buffered 0xA0 is dropped, then 0xA4 hits
        vq.push_back(mk(4'b0100, 32'hA0,  32'h0,   3'd0, 3'b100, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0000, 32'h0,   32'h0,   3'd0, 3'b100, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'hA4,  3'd0, 3'b001, 32'h0,   1'b1, 3'd5, 32'hA0));
        vq.push_back(mk(4'b0010, 32'h0,   32'hA4,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        // Priority: prefetch 0xE0 and demand 0xC0 together
        vq.push_back(mk(4'b0110, 32'hE0,  32'hC0,  3'd0, 3'b010, 32'hC0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0110, 32'hE0,  32'hC0,  3'd0, 3'b010, 32'hC0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0111, 32'hE0,  32'hC0,  3'd7, 3'b001, 32'h0,   1'b1, 3'd7, 32'hC0));
        vq.push_back(mk(4'b0110, 32'hE0,  32'hC0,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0100, 32'hE0,  32'h0,   3'd0, 3'b110, 32'hE0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0001, 32'h0,   32'h0,   3'd1, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));
        // Reset mid-fetch abandons the read and clears the buffered 0xE0 line
        vq.push_back(mk(4'b0010, 32'h0,   32'h200, 3'd0, 3'b010, 32'h200, 1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b1010, 32'h0,   32'h200, 3'd0, 3'b000, 32'h0,   1'b1, 3'd0, 32'h0));
        vq.push_back(mk(4'b0000, 32'h0,   32'h0,   3'd0, 3'b100, 32'h0,   1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0010, 32'h0,   32'hE4,  3'd0, 3'b010, 32'hE0,  1'b0, 3'd0, 32'h0));
        vq.push_back(mk(4'b0011, 32'h0,   32'hE4,  3'd2, 3'b001, 32'h0,   1'b1, 3'd2, 32'hE0));
        vq.push_back(mk(4'b0010, 32'h0,   32'hE4,  3'd0, 3'b000, 32'h0,   1'b0, 3'd0, 32'h0));

        for (int i = 0; i < vq.size(); i++) step(i, vq[i]);

        seq_demand_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
